// File: rtl/systolic_feed_sched.sv
// Feed scheduler for the systolic array: skews per-lane A/W FIFO reads into a diagonal wavefront.
// Optional RUN abort input is enabled by defining SYSTOLA_SCHED_ABORT_EN.
module systolic_feed_sched #(
  parameter int LANES  = 8,
  parameter int CNTW   = 8,
  parameter int STALLW = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CNTW-1:0]   klen,
  input  logic [LANES-1:0]  aemptys,
  input  logic [LANES-1:0]  wemptys,
`ifdef SYSTOLA_SCHED_ABORT_EN
  input  logic              abort,
`endif
  output logic [LANES-1:0]  rd_a,
  output logic [LANES-1:0]  rd_w,
  output logic              busy,
  output logic              done,
  output logic [STALLW-1:0] stall_cnt,
  output logic [1:0]        state_dbg
);

  // Read strobe semantics: a FIFO pops on every cycle its rd strobe is high; the strobe is
  // only raised when every active lane reports non-empty, so each strobe is a completed transfer.

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW = CNTW + LW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    t;
  logic [CNTW-1:0]  klen_q;
  logic [AW-1:0]    klen_ext;
  logic [AW-1:0]    last_t;
  logic [LANES-1:0] active;
  logic [LANES-1:0] strobe;
  logic             go;
  logic             abort_w;

`ifdef SYSTOLA_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign klen_ext = {{(AW-CNTW){1'b0}}, klen_q};
  assign last_t   = klen_ext + AW'(LANES - 2);

  // Widened arithmetic keeps i+klen_q exact even at the largest klen.
  always_comb begin
    active = '0;
    for (int i = 0; i < LANES; i++) begin
      active[i] = (t >= AW'(i)) && (t < (AW'(i) + klen_ext));
    end
  end

  assign go = ~|(active & (aemptys | wemptys));

  always_comb begin
    strobe = '0;
    if (state == RUN && go && !abort_w) begin
      strobe = active;
    end
  end

  assign rd_a      = strobe;
  assign rd_w      = strobe;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (klen != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort_w) begin
          state_nxt = DONE;
        end else if (go && (t == last_t)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      t         <= '0;
      klen_q    <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            klen_q    <= klen;
            stall_cnt <= '0;
            t         <= '0;
          end
        end
        RUN: begin
          if (!abort_w) begin
            if (go) begin
              t <= t + AW'(1);
            end else if (stall_cnt != '1) begin
              stall_cnt <= stall_cnt + STALLW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/systolic_feed_sched.md
Name: systolic_feed_sched

Overview:
- Sequences per-lane reads from the core input controller's activation and weight FIFOs.
- Produces the diagonal wavefront skew the systolic array needs: lane i starts reading i steps after lane 0.
- Stalls the whole wavefront whenever any active lane's FIFO is empty.
- Signals tile completion to the top-level core sequencer.

Parameters:
- LANES, 8, number of array rows/cols; one A FIFO and one W FIFO per lane.
- CNTW, 8, width of the per-tile vector count klen.
- STALLW, 16, width of the stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  tile start request; sampled only in IDLE.
- klen  in  CNTW  vectors per lane for this tile; latched when start is accepted.
- aemptys  in  LANES  per-lane activation FIFO empty flags.
- wemptys  in  LANES  per-lane weight FIFO empty flags.
- rd_a  out  LANES  per-lane activation FIFO read strobes.
- rd_w  out  LANES  per-lane weight FIFO read strobes.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at tile end.
- stall_cnt  out  STALLW  stalled cycles in the current/last tile.

Behaviour:
- Reset (rstn low, async): state=IDLE, step counter t=0, klen_q=0, stall_cnt=0. rd_a=rd_w=0, busy=0, done=0 immediately, without waiting for clk.
- State IDLE:
  - start=1 at posedge: latch klen_q=klen, clear stall_cnt, t=0.
  - Next state is RUN if klen!=0, else DONE.
- State RUN:
  - Lane i is active at step t iff i <= t < i+klen_q.
  - Each lane's active test uses CNTW+log2(LANES)+1-bit arithmetic, so there is no overflow at klen=2^CNTW-1.
  - go = no active lane has aemptys[i]=1 or wemptys[i]=1. Empty flags on inactive lanes are ignored.
  - rd_a[i]=rd_w[i]=active(i,t) & go. These are combinational from registered t/state and the current empty flags, giving zero-latency qualification.
  - go=1: t increments. If t==klen_q+LANES-2, next state is DONE.
  - go=0: t holds, no strobes are issued, and stall_cnt increments, saturating at all-ones.
  - Last step is t=klen_q+LANES-2. Stall-free RUN length is klen_q+LANES-1 cycles.
- State DONE: done=1 for exactly one cycle, then IDLE. busy=1.
- start outside IDLE is ignored, with no queuing.
- rd_a and rd_w are always identical; they are separate ports for floorplan fan-out.
- stall_cnt holds its value after DONE until the next accepted start.

Optional Feature:
- Macro: SYSTOLA_SCHED_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in RUN: all strobes forced to 0 that cycle, next state DONE (done pulses), t frozen.
  - abort=1 in IDLE or DONE: no effect.
  - abort has priority over go.
- Not defined: no abort port; RUN exits only via step completion or reset.

Test Plan:
- Reset: hold rstn=0 with FIFOs non-empty and start=1 → rd_a=rd_w=0, busy=0, done=0, stall_cnt=0 throughout.
- klen=4, all FIFOs non-empty, start pulse:
  - RUN lasts 11 cycles; lane0 strobes on RUN cycles 0-3, lane7 on cycles 7-10.
  - Each lane gets exactly 4 strobes; done pulses on cycle 11; stall_cnt=0.
- klen=4, aemptys[3]=1 for 2 cycles at t=5 → no strobes on any lane for those 2 cycles; RUN lasts 13 cycles; stall_cnt=2.
- klen=4, wemptys[7]=1 held while t<7 → no stall, RUN lasts 11 cycles; also klen=0 → done one cycle after start with zero strobes.
- Second start during RUN is ignored, and the tile count completes as for the first request. Then rstn=0 at t=6 → strobes drop asynchronously, state IDLE, and the next start runs a full clean tile.
- With SYSTOLA_SCHED_ABORT_EN: klen=8, abort at t=3 → no strobes that cycle, done pulses next cycle, then IDLE. Without the macro the build has no abort port.
